sdram_req_buffer: RTL and testbench

//  Command queue directly upstream of sdram_controller. Accepts write/read commands from a client over

---
 rtl/sdram_req_buffer_if.sv | 49 ++++
 rtl/sdram_req_buffer.sv | 147 ++++++++++++++
 tb/tb_sdram_req_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_req_buffer_if.sv
// Interface: sdram_req_buffer_if
// Bundles the client command channel (valid/ready), the read-data return and the
// controller-facing req/ack signals of sdram_req_buffer.
//   slave  : the buffer itself (accepts commands, issues requests)
//   master : the environment (client + controller side)
// Signals:
//   icmd_valid/ocmd_ready/icmd_we/icmd_addr/icmd_wdata : client command handshake
//   ordata_valid/ordata                                : read data return
//   ocount/obusy/oerr                                  : status
//   owrite_req/owrite_address/owrite_data/iwrite_ack   : controller write channel
//   oread_req/oread_address/iread_data/iread_ack       : controller read channel
interface sdram_req_buffer_if #(
    parameter int unsigned DEPTH = 8
) ();
    logic                         icmd_valid;
    logic                         ocmd_ready;
    logic                         icmd_we;
    logic [21:0]                  icmd_addr;
    logic [15:0]                  icmd_wdata;
    logic                         ordata_valid;
    logic [15:0]                  ordata;
    logic [$clog2(DEPTH+1)-1:0]   ocount;
    logic                         obusy;
    logic                         oerr;
    logic                         owrite_req;
    logic [21:0]                  owrite_address;
    logic [15:0]                  owrite_data;
    logic                         iwrite_ack;
    logic                         oread_req;
    logic [21:0]                  oread_address;
    logic [15:0]                  iread_data;
    logic                         iread_ack;

    modport slave (
        input  icmd_valid, icmd_we, icmd_addr, icmd_wdata,
        input  iwrite_ack, iread_data, iread_ack,
        output ocmd_ready, ordata_valid, ordata, ocount, obusy, oerr,
        output owrite_req, owrite_address, owrite_data,
        output oread_req, oread_address
    );

    modport master (
        output icmd_valid, icmd_we, icmd_addr, icmd_wdata,
        output iwrite_ack, iread_data, iread_ack,
        input  ocmd_ready, ordata_valid, ordata, ocount, obusy, oerr,
        input  owrite_req, owrite_address, owrite_data,
        input  oread_req, oread_address
    );
endinterface

// File: rtl/sdram_req_buffer.sv
// Module: sdram_req_buffer
// In-order command queue in front of sdram_controller. Client write/read commands
// are accepted over valid/ready into a DEPTH-entry FIFO and issued one at a time on
// the controller's req/ack interface; req, address and data stay stable until ack.
// Read data is returned with a one-cycle ordata_valid pulse. A watchdog drops a
// request that is not acked within TIMEOUT cycles and sets the sticky oerr flag.
// Ports:
//   iclk      : clock
//   ireset_n  : asynchronous active-low reset
//   bus       : sdram_req_buffer_if.slave (client channel, status, controller channel)
module sdram_req_buffer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              iclk,
    input  logic              ireset_n,
    sdram_req_buffer_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam int unsigned EW = 1 + 22 + 16;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_e;

    // FIFO entry layout: {we, addr[21:0], wdata[15:0]}
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ready_en_q;

    state_e        state_q;
    logic [WW-1:0] wd_q;
    logic          wreq_q, rreq_q, rvalid_q, err_q;
    logic [21:0]   waddr_q, raddr_q;
    logic [15:0]   wdata_q, rdata_q;

    logic          ready;
    logic          push, pop;
    logic [EW-1:0] head;

    // ready_en_q keeps ocmd_ready low until the first edge after reset release
    assign ready = ready_en_q & (count_q != CW'(DEPTH));
    assign push  = bus.icmd_valid & ready;
    assign pop   = (state_q == S_IDLE) & (count_q != '0);
    assign head  = mem[rd_ptr_q];

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge iclk) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.icmd_we, bus.icmd_addr, bus.icmd_wdata};
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            ready_en_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            wd_q       <= '0;
            wreq_q     <= 1'b0;
            rreq_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            rvalid_q   <= 1'b0;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase

            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        wd_q <= '0;
                        if (head[EW-1]) begin
                            state_q <= S_WRITE;
                            wreq_q  <= 1'b1;
                            waddr_q <= head[37:16];
                            wdata_q <= head[15:0];
                        end else begin
                            state_q <= S_READ;
                            rreq_q  <= 1'b1;
                            raddr_q <= head[37:16];
                        end
                    end
                end
                S_WRITE: begin
                    // Clearing req on the ack edge keeps the controller from seeing a stale req.
                    if (bus.iwrite_ack) begin
                        wreq_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (wd_q == WW'(TIMEOUT - 1)) begin
                        wreq_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WW'(1);
                    end
                end
                S_READ: begin
                    if (bus.iread_ack) begin
                        rreq_q   <= 1'b0;
                        rdata_q  <= bus.iread_data;
                        rvalid_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end else if (wd_q == WW'(TIMEOUT - 1)) begin
                        // Timed-out read is discarded: no data, no valid pulse.
                        rreq_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ocmd_ready     = ready;
    assign bus.ocount         = count_q;
    assign bus.obusy          = (state_q != S_IDLE) | (count_q != '0);
    assign bus.oerr           = err_q;
    assign bus.ordata_valid   = rvalid_q;
    assign bus.ordata         = rdata_q;
    assign bus.owrite_req     = wreq_q;
    assign bus.owrite_address = waddr_q;
    assign bus.owrite_data    = wdata_q;
    assign bus.oread_req      = rreq_q;
    assign bus.oread_address  = raddr_q;
endmodule

// File: tb/tb_sdram_req_buffer.sv
// Testbench: tb_sdram_req_buffer
// Scoreboard bench for sdram_req_buffer: accepted commands are queued as expected
// issues, a controller model checks each request against the queue and acks it,
// and read data it returns is queued and checked against ordata on ordata_valid.
module tb_sdram_req_buffer;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 1024;
    localparam int unsigned CW      = $clog2(DEPTH + 1);

    typedef struct packed {
        logic        we;
        logic [21:0] addr;
        logic [15:0] data;
    } cmd_t;

    logic iclk = 1'b0;
    logic ireset_n = 1'b0;
    always #5 iclk = ~iclk;

    sdram_req_buffer_if #(.DEPTH(DEPTH)) bus ();

    sdram_req_buffer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .iclk     (iclk),
        .ireset_n (ireset_n),
        .bus      (bus)
    );

    cmd_t        exp_q[$];
    logic [15:0] rd_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic stall_acks = 1'b0;
    logic force_wack = 1'b0;
    logic force_rack = 1'b0;
    int   ack_delay  = 2;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_rdata(input logic [21:0] addr);
        return (addr == 22'h3FFFFF) ? 16'hA5A5 : (addr[15:0] ^ 16'h5A5A);
    endfunction

    // Controller model: checks each issued request against the scoreboard, acks it.
    initial begin
        bit          seen;
        bit          acked;
        int          wait_cnt;
        cmd_t        cur;
        cmd_t        e;
        cmd_t        now_c;
        logic [15:0] rdat;
        seen = 0;
        acked = 0;
        wait_cnt = 0;
        bus.iwrite_ack = 1'b0;
        bus.iread_ack  = 1'b0;
        bus.iread_data = '0;
        forever begin
            @(negedge iclk);
            bus.iwrite_ack = force_wack;
            bus.iread_ack  = force_rack;
            if (!ireset_n) begin
                seen  = 0;
                acked = 0;
            end else if (acked) begin
                check_eq("req_drop_after_ack", {bus.owrite_req, bus.oread_req}, 64'h0);
                acked = 0;
            end else if (bus.owrite_req || bus.oread_req) begin
                now_c = bus.owrite_req ? {1'b1, bus.owrite_address, bus.owrite_data}
                                       : {1'b0, bus.oread_address, 16'h0};
                if (!seen) begin
                    seen = 1;
                    wait_cnt = 0;
                    cur = now_c;
                    check_eq("req_onehot", bus.owrite_req & bus.oread_req, 64'h0);
                    check_eq("issue_pending", exp_q.size() != 0, 64'h1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        if (!e.we) e.data = '0;
                        check_eq("issue_order", cur, e);
                    end
                end
                if (!stall_acks) begin
                    if (wait_cnt >= ack_delay) begin
                        check_eq("hold_stable", now_c, cur);
                        if (bus.owrite_req) begin
                            bus.iwrite_ack = 1'b1;
                        end else begin
                            rdat = model_rdata(bus.oread_address);
                            bus.iread_data = rdat;
                            bus.iread_ack  = 1'b1;
                            rd_q.push_back(rdat);
                        end
                        acked = 1;
                        seen  = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                seen = 0;
            end
        end
    end

    // Read-data monitor.
    initial begin
        bit          prev;
        logic [15:0] e;
        prev = 0;
        forever begin
            @(negedge iclk);
            if (bus.ordata_valid) begin
                check_eq("rdv_pulse_width", prev, 64'h0);
                check_eq("rdv_expected", rd_q.size() != 0, 64'h1);
                if (rd_q.size() != 0) begin
                    e = rd_q.pop_front();
                    check_eq("rdata", bus.ordata, e);
                end
            end
            prev = bus.ordata_valid;
        end
    end

    // Called at a negedge; returns at a later negedge with valid dropped.
    task automatic push_cmd(input logic we, input logic [21:0] addr, input logic [15:0] wd);
        bit ok;
        ok = 0;
        bus.icmd_valid = 1'b1;
        bus.icmd_we    = we;
        bus.icmd_addr  = addr;
        bus.icmd_wdata = wd;
        for (int g = 0; g < 2000 && !ok; g++) begin
            if (bus.ocmd_ready) begin
                exp_q.push_back('{we: we, addr: addr, data: wd});
                ok = 1;
            end
            @(negedge iclk);
        end
        bus.icmd_valid = 1'b0;
        check_eq("push_accept", ok, 64'h1);
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        while (bus.obusy && g < 3000) begin
            @(negedge iclk);
            g++;
        end
        check_eq(tag, bus.obusy, 64'h0);
        repeat (2) @(negedge iclk);
        check_eq({tag, "_sb"}, exp_q.size(), 64'h0);
    endtask

    initial begin
        int hi;
        int g;
        bus.icmd_valid = 1'b0;
        bus.icmd_we    = 1'b0;
        bus.icmd_addr  = '0;
        bus.icmd_wdata = '0;
        ireset_n = 1'b0;
        repeat (3) @(negedge iclk);
        check_eq("rst_ready", bus.ocmd_ready, 64'h0);
        check_eq("rst_outs", {bus.owrite_req, bus.oread_req, bus.ordata_valid, bus.obusy,
                              bus.oerr, bus.ocount}, 64'h0);
        ireset_n = 1'b1;

        // 1: idle after reset, spurious acks ignored
        for (int i = 0; i < 20; i++) begin
            @(negedge iclk);
            check_eq("t1_idle", {bus.owrite_req, bus.oread_req, bus.ocount, bus.ocmd_ready,
                                 bus.obusy}, {2'b00, CW'(0), 2'b10});
        end
        force_wack = 1'b1;
        force_rack = 1'b1;
        @(negedge iclk);
        force_wack = 1'b0;
        force_rack = 1'b0;
        repeat (3) @(negedge iclk);
        check_eq("t1_spurious", {bus.owrite_req, bus.oread_req, bus.obusy, bus.oerr,
                                 bus.ordata_valid, bus.ocount}, 64'h0);

        // 2: single write, latency and hold
        ack_delay = 5;
        push_cmd(1'b1, 22'h012345, 16'hBEEF);
        check_eq("t2_req_before", bus.owrite_req, 64'h0);
        check_eq("t2_count1", bus.ocount, 64'h1);
        @(negedge iclk);
        check_eq("t2_req_rise", bus.owrite_req, 64'h1);
        check_eq("t2_count0", bus.ocount, 64'h0);
        check_eq("t2_addr", bus.owrite_address, 64'h012345);
        check_eq("t2_data", bus.owrite_data, 64'hBEEF);
        force_rack = 1'b1;
        @(negedge iclk);
        force_rack = 1'b0;
        wait_idle("t2_done");
        check_eq("t2_addr_hold", bus.owrite_address, 64'h012345);

        // 3: single read
        ack_delay = 2;
        push_cmd(1'b0, 22'h3FFFFF, 16'h0);
        wait_idle("t3_done");
        check_eq("t3_ordata", bus.ordata, 64'hA5A5);
        check_eq("t3_raddr_hold", bus.oread_address, 64'h3FFFFF);

        // 4: fill with acks stalled, refuse 10th, drain in order
        stall_acks = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push_cmd(i[0] == 1'b0, 22'h100 + 22'(i * 37), 16'(16'h1000 + i));
        end
        check_eq("t4_full_count", bus.ocount, DEPTH);
        check_eq("t4_ready_low", bus.ocmd_ready, 64'h0);
        check_eq("t4_inflight", bus.owrite_req, 64'h1);
        bus.icmd_valid = 1'b1;
        bus.icmd_we    = 1'b1;
        bus.icmd_addr  = 22'h3ABCDE;
        bus.icmd_wdata = 16'hDEAD;
        repeat (3) @(negedge iclk);
        bus.icmd_valid = 1'b0;
        check_eq("t4_refused", bus.ocount, DEPTH);
        ack_delay  = 1;
        stall_acks = 1'b0;
        wait_idle("t4_drain");

        // 5: simultaneous push and pop at count 3, then wrap-around
        stall_acks = 1'b1;
        ack_delay  = 0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(i[0], 22'h200 + 22'(i), 16'(16'h2000 + i));
        end
        check_eq("t5_count3", bus.ocount, 64'h3);
        @(posedge iclk);
        stall_acks = 1'b0;
        @(negedge iclk);
        g = 0;
        while (!(!bus.owrite_req && !bus.oread_req && bus.ocount == CW'(3)) && g < 20) begin
            @(negedge iclk);
            g++;
        end
        check_eq("t5_pop_window", g < 20, 64'h1);
        bus.icmd_valid = 1'b1;
        bus.icmd_we    = 1'b1;
        bus.icmd_addr  = 22'h2FF;
        bus.icmd_wdata = 16'h2FFF;
        if (bus.ocmd_ready) exp_q.push_back('{we: 1'b1, addr: 22'h2FF, data: 16'h2FFF});
        @(negedge iclk);
        bus.icmd_valid = 1'b0;
        check_eq("t5_pushpop_count", bus.ocount, 64'h3);
        check_eq("t5_issued", bus.owrite_req | bus.oread_req, 64'h1);
        wait_idle("t5_drain");
        for (int i = 0; i < 20; i++) begin
            push_cmd($urandom_range(0, 1) == 1, 22'($urandom), 16'($urandom));
        end
        wait_idle("t5_wrap");

        // 6: watchdog timeout on a read
        stall_acks = 1'b1;
        push_cmd(1'b0, 22'h2AAAAA, 16'h0);
        g = 0;
        while (!bus.oread_req && g < 20) begin
            @(negedge iclk);
            g++;
        end
        hi = 0;
        while (bus.oread_req && hi < TIMEOUT + 100) begin
            @(negedge iclk);
            hi++;
        end
        check_eq("t6_req_cycles", hi, TIMEOUT);
        check_eq("t6_oerr", bus.oerr, 64'h1);
        check_eq("t6_req_low", bus.oread_req, 64'h0);
        check_eq("t6_idle", bus.obusy, 64'h0);
        stall_acks = 1'b0;
        push_cmd(1'b1, 22'h155555, 16'h1234);
        wait_idle("t6_next");
        check_eq("t6_oerr_sticky", bus.oerr, 64'h1);

        // 6b: reset mid-read
        stall_acks = 1'b1;
        push_cmd(1'b0, 22'h0ABCDE, 16'h0);
        push_cmd(1'b1, 22'h000001, 16'h1111);
        push_cmd(1'b1, 22'h000002, 16'h2222);
        g = 0;
        while (!bus.oread_req && g < 20) begin
            @(negedge iclk);
            g++;
        end
        check_eq("t6b_read_inflight", bus.oread_req, 64'h1);
        #2;
        ireset_n = 1'b0;
        #1;
        check_eq("t6b_req_async", {bus.owrite_req, bus.oread_req}, 64'h0);
        check_eq("t6b_count", bus.ocount, 64'h0);
        check_eq("t6b_oerr", bus.oerr, 64'h0);
        check_eq("t6b_ready", bus.ocmd_ready, 64'h0);
        exp_q.delete();
        rd_q.delete();
        @(negedge iclk);
        ireset_n   = 1'b1;
        stall_acks = 1'b0;
        @(negedge iclk);
        check_eq("t6b_ready_after", bus.ocmd_ready, 64'h1);
        check_eq("t6b_quiet", {bus.owrite_req, bus.oread_req, bus.obusy, bus.ocount}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
